// File: rtl/prime_pkg.sv
// Shared definitions for the prime range scanner.
//   scan_state_t : scanner FSM states (IDLE, SCAN, DRAIN)
//   DEF_WIDTH    : default candidate / range width, matches the prime checker input
package prime_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } scan_state_t;

   localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/prime_fifo.sv
// Synchronous FIFO holding primes found by the scanner.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data; ignored when full unless a pop happens together
//   push_data  : entry to write
//   pop        : remove head entry; ignored when empty
//   full/empty : occupancy flags
//   head       : current head entry, 0 while empty
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// There is no write-to-read bypass: an entry pushed into an empty FIFO
// becomes visible on the following cycle.
module prime_fifo #(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so push-when-full is legal then.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/prime_range_scanner.sv
// Walks an inclusive range [range_lo, range_hi], one candidate per cycle,
// through an external combinational prime checker and streams the primes
// out through a small FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a scan (accepted only in IDLE)
//   range_lo/range_hi : inclusive bounds, sampled on an accepted start
//   busy              : high while scanning or draining
//   done              : one-cycle pulse at end of scan (or empty range)
//   cand_num          : current candidate, drives the checker
//   cand_is_prime     : checker result for cand_num
//   prime_valid/ready : output stream handshake
//   prime_data        : output stream head entry
//   prime_count       : primes found in current/last scan, saturating
module prime_range_scanner
   import prime_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   range_lo,
   input  logic [WIDTH-1:0]   range_hi,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   cand_num,
   input  logic               cand_is_prime,
   output logic               prime_valid,
   input  logic               prime_ready,
   output logic [WIDTH-1:0]   prime_data,
   output logic [COUNT_W-1:0] prime_count
);

   scan_state_t      state;
   logic [WIDTH-1:0] hi_r;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push_ok;
   logic             push;
   logic             advance;

   assign prime_valid = !fifo_empty;
   assign push_ok     = !fifo_full || (prime_valid && prime_ready);
   assign push        = (state == SCAN) && cand_is_prime && push_ok;
   // A prime that cannot be stored holds the scan on this candidate.
   assign advance     = (state == SCAN) && (!cand_is_prime || push_ok);

   prime_fifo #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (cand_num),
      .pop       (prime_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (prime_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         cand_num    <= '0;
         hi_r        <= '0;
         prime_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  prime_count <= '0;
                  if (range_lo <= range_hi) begin
                     cand_num <= range_lo;
                     hi_r     <= range_hi;
                     busy     <= 1'b1;
                     state    <= SCAN;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (push && prime_count != '1)
                  prime_count <= prime_count + 1'b1;
               // Compare before increment so hi = all-ones never wraps.
               if (advance) begin
                  if (cand_num == hi_r) state    <= DRAIN;
                  else                  cand_num <= cand_num + 1'b1;
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prime_range_scanner.sv
module tb_prime_range_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] range_lo = '0;
   logic [31:0] range_hi = '0;
   logic        busy;
   logic        done;
   logic [31:0] cand_num;
   logic        cand_is_prime;
   logic        prime_valid;
   logic        prime_ready = 1'b0;
   logic [31:0] prime_data;
   logic [15:0] prime_count;

   int          tests = 0;
   int          fails = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   bit          any_valid = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   prime_range_scanner dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .range_lo      (range_lo),
      .range_hi      (range_hi),
      .busy          (busy),
      .done          (done),
      .cand_num      (cand_num),
      .cand_is_prime (cand_is_prime),
      .prime_valid   (prime_valid),
      .prime_ready   (prime_ready),
      .prime_data    (prime_data),
      .prime_count   (prime_count)
   );

   // Reference prime checker standing in for the integrator's block.
   function automatic bit is_prime(logic [31:0] n);
      longint unsigned v = {32'd0, n};
      if (v < 2) return 0;
      if (v < 4) return 1;
      if (v % 2 == 0) return 0;
      for (longint unsigned d = 3; d * d <= v; d += 2)
         if (v % d == 0) return 0;
      return 1;
   endfunction

   assign cand_is_prime = is_prime(cand_num);

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted output beat.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_cnt++;
         if (prime_valid) any_valid = 1;
         if (prime_valid && prime_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL stream: unexpected output %0d (0x%08h)", prime_data, prime_data);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (prime_data !== e) begin
                  fails++;
                  $display("FAIL stream: got %0d (0x%08h) expected %0d (0x%08h)", prime_data, prime_data, e, e);
               end
            end
         end
      end
   end

   task automatic do_start(logic [31:0] lo, logic [31:0] hi);
      @(posedge clk); #1;
      start = 1; range_lo = lo; range_hi = hi;
      @(posedge clk); #1;
      start = 0;
   endtask

   // Returns the number of negedges after the start edge until done is seen.
   task automatic wait_done(string name, int max_cyc, output int lat);
      lat = 0;
      for (int i = 1; i <= max_cyc; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            @(negedge clk);
            check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
            return;
         end
      end
      tests++; fails++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, max_cyc);
   endtask

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int          lat;
      bit          stable;
      logic [31:0] p1 [8]  = '{2, 3, 5, 7, 11, 13, 17, 19};
      logic [31:0] p4 [10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};

      // Reset state
      cycles(3);
      @(negedge clk);
      check("rst_busy",  {31'd0, busy}, 0);
      check("rst_done",  {31'd0, done}, 0);
      check("rst_cand",  cand_num, 0);
      check("rst_valid", {31'd0, prime_valid}, 0);
      check("rst_data",  prime_data, 0);
      check("rst_count", {16'd0, prime_count}, 0);
      @(posedge clk); #1 rst = 0;

      // 1: range 1..20, free-flowing consumer
      prime_ready = 1;
      foreach (p1[i]) exp_q.push_back(p1[i]);
      do_start(1, 20);
      wait_done("t1", 200, lat);
      exp_done++;
      check("t1_count", {16'd0, prime_count}, 8);
      check("t1_left",  exp_q.size(), 0);
      check("t1_done_cnt", done_cnt, exp_done);

      // 3: inverted range -> immediate done, count cleared
      do_start(20, 10);
      @(negedge clk);
      check("t3_done", {31'd0, done}, 1);
      check("t3_busy", {31'd0, busy}, 0);
      check("t3_count", {16'd0, prime_count}, 0);
      cycles(2);
      exp_done++;
      check("t3_done_cnt", done_cnt, exp_done);

      // 2: prime-free range 24..28
      any_valid = 0;
      do_start(24, 28);
      wait_done("t2", 50, lat);
      exp_done++;
      check("t2_latency", lat, 7);
      check("t2_valid_seen", {31'd0, any_valid}, 0);
      check("t2_count", {16'd0, prime_count}, 0);

      // 4: backpressure with a full FIFO
      prime_ready = 0;
      foreach (p4[i]) exp_q.push_back(p4[i]);
      do_start(2, 30);
      stable = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i >= 2 && prime_data != 32'd2) stable = 0;
      end
      check("t4_stall_cand", cand_num, 11);
      check("t4_stall_valid", {31'd0, prime_valid}, 1);
      check("t4_stall_busy", {31'd0, busy}, 1);
      check("t4_head_stable", {31'd0, stable}, 1);
      check("t4_stall_count", {16'd0, prime_count}, 4);
      @(posedge clk); #1 prime_ready = 1;
      wait_done("t4", 200, lat);
      exp_done++;
      check("t4_count", {16'd0, prime_count}, 10);
      check("t4_left", exp_q.size(), 0);

      // 5: top of the 32-bit range
      exp_q.push_back(32'hFFFFFFFB);
      do_start(32'hFFFFFFF0, 32'hFFFFFFFF);
      wait_done("t5", 100, lat);
      exp_done++;
      check("t5_count", {16'd0, prime_count}, 1);
      check("t5_cand_end", cand_num, 32'hFFFFFFFF);
      check("t5_left", exp_q.size(), 0);
      check("t5_done_cnt", done_cnt, exp_done);

      // 6: reset mid-scan with FIFO partially full
      prime_ready = 0;
      do_start(1, 100);
      cycles(3);
      @(negedge clk);
      check("t6_pre_valid", {31'd0, prime_valid}, 1);
      @(posedge clk); #1 rst = 1;
      cycles(2);
      rst = 0;
      exp_q.delete();
      @(negedge clk);
      check("t6_rst_busy",  {31'd0, busy}, 0);
      check("t6_rst_cand",  cand_num, 0);
      check("t6_rst_valid", {31'd0, prime_valid}, 0);
      check("t6_rst_data",  prime_data, 0);
      check("t6_rst_count", {16'd0, prime_count}, 0);
      cycles(3);
      check("t6_no_done", done_cnt, exp_done);
      prime_ready = 1;
      exp_q.push_back(2);
      exp_q.push_back(3);
      do_start(2, 3);
      wait_done("t6", 50, lat);
      exp_done++;
      check("t6_count", {16'd0, prime_count}, 2);
      check("t6_left", exp_q.size(), 0);
      cycles(2);
      check("final_done_cnt", done_cnt, exp_done);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
